mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, 1, memory read-data latency in cycles after mem_en_o; legal range 1..4.
REQ-002 Parameter: XLEN, riscv_pkg::XLEN (32), address/data width.
REQ-003 Ports, clock and reset first; one clock; reset is synchronous and active-high:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- if_valid_i  in  1  fetch port request valid
- if_ready_o  out  1  fetch port request accepted this cycle
- if_addr_i  in  XLEN  fetch byte address
- if_rsp_valid_o  out  1  fetch response strobe, one cycle
- if_rdata_o  out  XLEN  fetch response data
- ls_valid_i  in  1  load/store port request valid
- ls_ready_o  out  1  load/store request accepted this cycle
- ls_addr_i  in  XLEN  load/store byte address
- ls_we_i  in  1  1 = store
- ls_wdata_i  in  XLEN  store data
- ls_wmask_i  in  4  store byte mask
- ls_rsp_valid_o  out  1  load/store response strobe (loads and stores)
- ls_rdata_o  out  XLEN  load data
- mem_en_o  out  1  memory access strobe, one cycle per transaction
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  XLEN  memory byte address
- mem_wdata_o  out  XLEN  memory write data
- mem_wmask_o  out  4  memory byte mask
- mem_rdata_i  in  XLEN  memory read data, valid LATENCY cycles after mem_en_o, held until next access
- grant_o  out  2  one-hot owner of current transaction, 0 when IDLE

Function
REQ-004 FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-005 IDLE: if any valid, assert ready (combinational) to exactly one winner; on handshake latch addr/we/wdata/wmask and owner, go ISSUE; else stay IDLE.
REQ-006 Fetch port transactions SHALL be reads: mem_we_o=0, mem_wmask_o=4'b0000.
REQ-007 Tie (both valid in IDLE): grant the port not granted last (round-robin); single valid: grant it regardless of history.
REQ-008 ISSUE (handshake cycle T+1): mem_en_o=1 with latched command, for exactly one cycle; next WAIT if LATENCY>1 else RESP.
REQ-009 WAIT: down-counter loaded with LATENCY-2 on ISSUE exit; leave to RESP when counter is 0; total WAIT cycles = LATENCY-1.
REQ-010 RESP (cycle T+1+LATENCY): owner's rsp_valid=1 for one cycle, rdata=mem_rdata_i; other port's rsp_valid=0; next IDLE.
REQ-011 Stores also get rsp_valid in RESP; rdata content then undefined, bench ignores it.
REQ-012 Earliest next handshake: cycle T+2+LATENCY (back in IDLE); ready=0 in ISSUE/WAIT/RESP.
REQ-013 Requester may drop valid before ready without effect; latched command is immune to input changes after handshake.
REQ-014 mem_addr_o passes byte address unmodified; no alignment check.
REQ-015 Outside ISSUE: mem_en_o=0, mem_we_o=0; other mem_* outputs hold latched values.
REQ-016 rdata outputs SHALL be 0 whenever their rsp_valid is 0.

Reset
REQ-017 rst high at a clock edge: state IDLE, counter 0, latched command 0, last-granted = ls (so fetch wins first tie).
REQ-018 While rst high: all ready, rsp_valid, mem_en_o, mem_we_o, grant_o outputs 0; all data outputs 0.
REQ-019 Reset mid-transaction aborts it: no response is ever issued for it, no mem_en_o after reset edge.

Structure
REQ-020 riscv_pkg holds XLEN, typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP}, and constants PORT_IF=0, PORT_LS=1.
REQ-021 One sub-module: rr_arb2, combinational 2-request round-robin picker (req[1:0], last, gnt[1:0]); last-granted register lives in mem_arbiter.

Verification
REQ-022 LATENCY=1, fetch only, if_addr=0x10, mem returns 0x00500093 -> mem_en at T+1, if_rsp_valid at T+2 with 0x00500093, ready low T+1..T+2.
REQ-023 After reset both valid in same cycle -> fetch granted first, ls granted at next IDLE; with both held, grants alternate if,ls,if,ls.
REQ-024 LATENCY=3, store addr 0x200 data 0xDEADBEEF mask 0011 -> one mem_en with we=1 mask 0011 at T+1, ls_rsp_valid at T+4, if_rsp_valid never.
REQ-025 Change ls_addr_i to 0x300 the cycle after handshake on 0x100 -> mem_addr_o=0x100.
REQ-026 Assert rst during WAIT (LATENCY=4) -> no rsp_valid, outputs 0 next cycle, fresh fetch request handled normally after release.
REQ-027 Back-to-back ls loads, LATENCY=2 -> handshakes exactly 4 cycles apart, one rsp per handshake.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: datapath width, arbiter FSM states and port indices.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int PORT_IF = 0;
    localparam int PORT_LS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; purely combinational, history is held by the caller.
// Bit 0 is the fetch port, bit 1 the load/store port; last=1 means load/store won last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Lone requester always wins; a tie goes to the port that did not win last.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one fixed-latency memory port.
// Only one transaction is outstanding: IDLE -> ISSUE -> WAIT (LATENCY-1 cycles) -> RESP -> IDLE.
module mem_arbiter #(
    parameter int LATENCY = 1,
    parameter int XLEN    = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_rsp_valid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            ls_valid_i,
    output logic            ls_ready_o,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic            ls_we_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    input  logic [3:0]      ls_wmask_i,
    output logic            ls_rsp_valid_o,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [1:0]      grant_o
);

    import riscv_pkg::*;

    // WAIT counts down from LATENCY-2 to 0, so it spans LATENCY-1 cycles.
    localparam logic [1:0] WAIT_LOAD = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    arb_state_t      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            last_q, last_d;    // 1 = load/store port won the last arbitration
    logic            owner_q, owner_d;  // 1 = load/store port owns the current transaction
    logic [XLEN-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;

    logic            idle;
    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            rsp;

    // Requests are only considered while idle and out of reset, so a grant is a handshake.
    assign idle = (state_q == IDLE) && !rst;
    assign req  = {ls_valid_i, if_valid_i} & {2{idle}};

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_q),
        .gnt  (gnt)
    );

    // Next-state logic: latch the winner's command on handshake, then walk the fixed latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = ISSUE;
                    owner_d = gnt[PORT_LS];
                    last_d  = gnt[PORT_LS];
                    if (gnt[PORT_LS]) begin
                        addr_d  = ls_addr_i;
                        we_d    = ls_we_i;
                        wdata_d = ls_wdata_i;
                        wmask_d = ls_wmask_i;
                    end else begin
                        // Fetches are always reads with no byte lanes enabled.
                        addr_d  = if_addr_i;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        wmask_d = 4'b0000;
                    end
                end
            end
            ISSUE: begin
                if (LATENCY > 1) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched command; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // Output decode from registered state; everything is forced to zero while rst is high.
    always_comb begin
        rsp            = !rst && (state_q == RESP);
        if_ready_o     = gnt[PORT_IF];
        ls_ready_o     = gnt[PORT_LS];
        mem_en_o       = !rst && (state_q == ISSUE);
        mem_we_o       = mem_en_o && we_q;
        mem_addr_o     = rst ? '0 : addr_q;
        mem_wdata_o    = rst ? '0 : wdata_q;
        mem_wmask_o    = rst ? 4'b0000 : wmask_q;
        if_rsp_valid_o = rsp && !owner_q;
        ls_rsp_valid_o = rsp && owner_q;
        if_rdata_o     = if_rsp_valid_o ? mem_rdata_i : '0;
        ls_rdata_o     = ls_rsp_valid_o ? mem_rdata_i : '0;
        grant_o        = 2'b00;
        if (!rst && (state_q != IDLE)) begin
            grant_o = owner_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four instances at LATENCY 1..4 share the request inputs,
// each with its own fixed-latency memory model; each step targets one instance.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        ls_valid;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;

    logic        if_ready     [1:4];
    logic        if_rsp_valid [1:4];
    logic [31:0] if_rdata     [1:4];
    logic        ls_ready     [1:4];
    logic        ls_rsp_valid [1:4];
    logic [31:0] ls_rdata     [1:4];
    logic        mem_en       [1:4];
    logic        mem_we       [1:4];
    logic [31:0] mem_addr     [1:4];
    logic [31:0] mem_wdata    [1:4];
    logic [3:0]  mem_wmask    [1:4];
    logic [1:0]  grant        [1:4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h10) return 32'h00500093;
        return a ^ 32'h5A5A0000;
    endfunction

    for (genvar g = 1; g <= 4; g++) begin : g_lat
        logic [31:0] rdata_m;
        logic [31:0] pend_addr;
        int          pend_cnt;

        mem_arbiter #(.LATENCY(g), .XLEN(32)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .if_valid_i     (if_valid),
            .if_ready_o     (if_ready[g]),
            .if_addr_i      (if_addr),
            .if_rsp_valid_o (if_rsp_valid[g]),
            .if_rdata_o     (if_rdata[g]),
            .ls_valid_i     (ls_valid),
            .ls_ready_o     (ls_ready[g]),
            .ls_addr_i      (ls_addr),
            .ls_we_i        (ls_we),
            .ls_wdata_i     (ls_wdata),
            .ls_wmask_i     (ls_wmask),
            .ls_rsp_valid_o (ls_rsp_valid[g]),
            .ls_rdata_o     (ls_rdata[g]),
            .mem_en_o       (mem_en[g]),
            .mem_we_o       (mem_we[g]),
            .mem_addr_o     (mem_addr[g]),
            .mem_wdata_o    (mem_wdata[g]),
            .mem_wmask_o    (mem_wmask[g]),
            .mem_rdata_i    (rdata_m),
            .grant_o        (grant[g])
        );

        // Memory model: read data appears g cycles after the mem_en cycle, junk before that.
        always @(posedge clk) begin
            if (rst) begin
                pend_cnt <= 0;
                rdata_m  <= 32'h0;
            end else if (mem_en[g] && !mem_we[g]) begin
                pend_addr <= mem_addr[g];
                if (g == 1) begin
                    rdata_m <= memval(mem_addr[g]);
                end else begin
                    rdata_m  <= 32'hBAD0BAD0;
                    pend_cnt <= g - 1;
                end
            end else if (pend_cnt != 0) begin
                pend_cnt <= pend_cnt - 1;
                if (pend_cnt == 1) rdata_m <= memval(pend_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (where inputs are driven).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle (where outputs are sampled).
    task automatic mid();
        #4;
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0;
        if_addr  = 32'h0;
        ls_valid = 1'b0;
        ls_addr  = 32'h0;
        ls_we    = 1'b0;
        ls_wdata = 32'h0;
        ls_wmask = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g;
        int hs;
        int rsps;
        int last_hs;
        int ens;
        int ifr;

        // Reset state: outputs stay low even with requests pending.
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        if_valid = 1'b1;
        ls_valid = 1'b1;
        if_addr  = 32'h44;
        mid();
        check("rst_if_ready", if_ready[1], 1'b0);
        check("rst_ls_ready", ls_ready[1], 1'b0);
        check("rst_grant", grant[1], 2'b00);
        check("rst_mem_en", mem_en[1], 1'b0);
        check("rst_mem_addr", mem_addr[1], 32'h0);
        check("rst_if_rsp", if_rsp_valid[1], 1'b0);

        // LATENCY=1 single fetch of 0x10.
        do_reset();
        if_valid = 1'b1;
        if_addr  = 32'h10;
        mid();
        check("f1_ready_T", if_ready[1], 1'b1);
        check("f1_grant_T", grant[1], 2'b00);
        step();
        if_valid = 1'b0;
        if_addr  = 32'hFFF0;
        mid();
        check("f1_en_T1", mem_en[1], 1'b1);
        check("f1_we_T1", mem_we[1], 1'b0);
        check("f1_mask_T1", mem_wmask[1], 4'b0000);
        check("f1_addr_T1", mem_addr[1], 32'h10);
        check("f1_grant_T1", grant[1], 2'b01);
        check("f1_ready_T1", if_ready[1], 1'b0);
        step();
        if_valid = 1'b1;
        mid();
        check("f1_rsp_T2", if_rsp_valid[1], 1'b1);
        check("f1_rdata_T2", if_rdata[1], 32'h00500093);
        check("f1_ls_rsp_T2", ls_rsp_valid[1], 1'b0);
        check("f1_en_T2", mem_en[1], 1'b0);
        check("f1_ready_T2", if_ready[1], 1'b0);
        step();
        if_valid = 1'b0;
        mid();
        check("f1_rsp_T3", if_rsp_valid[1], 1'b0);
        check("f1_rdata_T3", if_rdata[1], 32'h0);
        check("f1_grant_T3", grant[1], 2'b00);

        // Round-robin with both ports held valid: if, ls, if, ls.
        do_reset();
        if_valid = 1'b1;
        if_addr  = 32'h40;
        ls_valid = 1'b1;
        ls_addr  = 32'h80;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            mid();
            check("rr_if_ready", if_ready[1], exp_g[0]);
            check("rr_ls_ready", ls_ready[1], exp_g[1]);
            step();
            mid();
            check("rr_grant", grant[1], exp_g);
            check("rr_addr", mem_addr[1], exp_g[0] ? 32'h40 : 32'h80);
            step();
            mid();
            check("rr_if_rsp", if_rsp_valid[1], exp_g[0]);
            check("rr_ls_rsp", ls_rsp_valid[1], exp_g[1]);
            check("rr_ls_rdata", ls_rdata[1], exp_g[1] ? 32'h5A5A0080 : 32'h0);
            step();
        end
        idle_inputs();

        // LATENCY=3 store.
        do_reset();
        ls_valid = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h200;
        ls_wdata = 32'hDEADBEEF;
        ls_wmask = 4'b0011;
        mid();
        check("st_ready_T", ls_ready[3], 1'b1);
        step();
        ls_valid = 1'b0;
        ls_wdata = 32'h0;
        ls_wmask = 4'b1111;
        mid();
        check("st_en_T1", mem_en[3], 1'b1);
        check("st_we_T1", mem_we[3], 1'b1);
        check("st_mask_T1", mem_wmask[3], 4'b0011);
        check("st_wdata_T1", mem_wdata[3], 32'hDEADBEEF);
        check("st_addr_T1", mem_addr[3], 32'h200);
        ens = 1;
        ifr = 0;
        step();
        for (int c = 2; c <= 5; c++) begin
            mid();
            ens += int'(mem_en[3]);
            ifr += int'(if_rsp_valid[3]);
            check("st_ls_rsp", ls_rsp_valid[3], (c == 4));
            step();
        end
        check("st_en_count", ens, 1);
        check("st_if_rsp_count", ifr, 0);
        mid();
        check("st_we_after", mem_we[3], 1'b0);
        check("st_mask_held", mem_wmask[3], 4'b0011);

        // LATENCY=2 command immune to address change after handshake.
        do_reset();
        ls_valid = 1'b1;
        ls_addr  = 32'h100;
        mid();
        check("imm_ready_T", ls_ready[2], 1'b1);
        step();
        ls_valid = 1'b0;
        ls_addr  = 32'h300;
        mid();
        check("imm_en_T1", mem_en[2], 1'b1);
        check("imm_addr_T1", mem_addr[2], 32'h100);
        step();
        mid();
        check("imm_en_T2", mem_en[2], 1'b0);
        check("imm_addr_T2", mem_addr[2], 32'h100);
        step();
        mid();
        check("imm_rsp_T3", ls_rsp_valid[2], 1'b1);
        check("imm_rdata_T3", ls_rdata[2], 32'h5A5A0100);
        step();

        // LATENCY=2 back-to-back loads: handshakes 4 cycles apart.
        do_reset();
        ls_valid = 1'b1;
        ls_addr  = 32'h100;
        hs = 0;
        rsps = 0;
        last_hs = 0;
        for (int c = 0; c < 20; c++) begin
            mid();
            if (ls_ready[2]) begin
                if (hs > 0) check("b2b_gap", c - last_hs, 4);
                last_hs = c;
                hs++;
            end
            if (ls_rsp_valid[2]) rsps++;
            step();
        end
        check("b2b_hs_count", hs, 5);
        check("b2b_rsp_count", rsps, 5);
        idle_inputs();

        // LATENCY=4 reset during WAIT aborts the fetch.
        do_reset();
        if_valid = 1'b1;
        if_addr  = 32'h10;
        mid();
        check("ab_ready_T", if_ready[4], 1'b1);
        step();
        if_valid = 1'b0;
        mid();
        check("ab_en_T1", mem_en[4], 1'b1);
        step();
        mid();
        check("ab_grant_T2", grant[4], 2'b01);
        step();
        rst = 1'b1;
        mid();
        check("ab_rst_grant", grant[4], 2'b00);
        check("ab_rst_addr", mem_addr[4], 32'h0);
        check("ab_rst_rsp", if_rsp_valid[4], 1'b0);
        step();
        rst = 1'b0;
        mid();
        check("ab_post_addr", mem_addr[4], 32'h0);
        check("ab_post_grant", grant[4], 2'b00);
        ens = 0;
        ifr = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            mid();
            ens += int'(mem_en[4]);
            ifr += int'(if_rsp_valid[4]);
        end
        check("ab_no_en", ens, 0);
        check("ab_no_rsp", ifr, 0);
        step();
        if_valid = 1'b1;
        if_addr  = 32'h10;
        mid();
        check("ab_new_ready", if_ready[4], 1'b1);
        step();
        if_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            mid();
            check("ab_new_rsp", if_rsp_valid[4], (c == 5));
            check("ab_new_rdata", if_rdata[4], (c == 5) ? 32'h00500093 : 32'h0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
